// File: rtl/wino_tile_scheduler.sv
// rtl/wino_tile_scheduler.sv - Winograd PE-array edge sequencer for one layer pass
module wino_tile_scheduler #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] cfg_block_cnt_i,
  input  logic [ADDR_W-1:0] cfg_od_cnt_i,
  input  logic              cfg_size_type_i,
  input  logic              stall_i,
  output logic              data_rd_en_o,
  output logic [ADDR_W-1:0] data_rd_addr_o,
  output logic              wt_rd_en_o,
  output logic [ADDR_W-1:0] wt_rd_addr_o,
  output logic              pe_data_valid_o,
  output logic [ADDR_W-1:0] pe_data_addr_o,
  output logic              pe_size_type_o,
  output logic [ADDR_W-1:0] pe_block_cnt_o,
  output logic              pe_weight_valid_o,
  output logic [ADDR_W-1:0] pe_weight_od_o,
  input  logic              result_valid_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_blk;
  logic [ADDR_W-1:0] r_od;
  logic [ADDR_W-1:0] r_block_cnt;
  logic [ADDR_W-1:0] r_od_cnt;
  logic              r_size_type;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_rcvd;
  logic [CNT_W-1:0]  r_total;
  logic              r_pe_valid;
  logic [ADDR_W-1:0] r_pe_data_addr;
  logic [ADDR_W-1:0] r_pe_wt_od;

  logic              w_issue;
  logic              w_last_blk;
  logic              w_last_issue;
  logic              w_count_result;
  logic [CNT_W-1:0]  w_rcvd_next;

  // A read pair goes out every ISSUE cycle that is not held off by backpressure.
  assign w_issue        = (r_state == S_ISSUE) && !stall_i;
  assign w_last_blk     = (r_blk == r_block_cnt - ADDR_W'(1));
  assign w_last_issue   = w_last_blk && (r_od == r_od_cnt - ADDR_W'(1));
  // Results only count while a pass is actually in flight.
  assign w_count_result = result_valid_i && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_rcvd_next    = r_rcvd + CNT_W'(w_count_result);

  // Buffer read strobes are combinational so the data lands one cycle later.
  assign data_rd_en_o   = w_issue;
  assign wt_rd_en_o     = w_issue;
  assign data_rd_addr_o = w_issue ? r_blk : '0;
  assign wt_rd_addr_o   = w_issue ? r_od : '0;

  assign pe_data_valid_o   = r_pe_valid;
  assign pe_weight_valid_o = r_pe_valid;
  assign pe_data_addr_o    = r_pe_data_addr;
  assign pe_weight_od_o    = r_pe_wt_od;
  assign pe_size_type_o    = r_size_type;
  assign pe_block_cnt_o    = r_block_cnt;
  assign busy_o            = (r_state != S_IDLE);
  assign done_o            = (r_state == S_DONE);

  // Pass sequencer: config latch, (od, blk) walk, PE sideband pipeline and result accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_blk          <= '0;
      r_od           <= '0;
      r_block_cnt    <= '0;
      r_od_cnt       <= '0;
      r_size_type    <= 1'b0;
      r_issued       <= '0;
      r_rcvd         <= '0;
      r_total        <= '0;
      r_pe_valid     <= 1'b0;
      r_pe_data_addr <= '0;
      r_pe_wt_od     <= '0;
    end else begin
      r_pe_valid     <= w_issue;
      r_pe_data_addr <= w_issue ? r_blk : '0;
      r_pe_wt_od     <= w_issue ? r_od : '0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_block_cnt <= cfg_block_cnt_i;
            r_od_cnt    <= cfg_od_cnt_i;
            r_size_type <= cfg_size_type_i;
            r_blk       <= '0;
            r_od        <= '0;
            r_issued    <= '0;
            r_rcvd      <= '0;
            r_total     <= CNT_W'(cfg_od_cnt_i) * CNT_W'(cfg_block_cnt_i);
            if ((cfg_block_cnt_i == '0) || (cfg_od_cnt_i == '0)) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_rcvd <= w_rcvd_next;
          if (w_issue) begin
            r_issued <= r_issued + CNT_W'(1);
            if (w_last_blk) begin
              r_blk <= '0;
              r_od  <= r_od + ADDR_W'(1);
            end else begin
              r_blk <= r_blk + ADDR_W'(1);
            end
            if (w_last_issue) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_rcvd <= w_rcvd_next;
          if (w_rcvd_next == r_total) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wino_tile_scheduler.sv
// tb/tb_wino_tile_scheduler.sv - randomized model-checked bench for wino_tile_scheduler
module tb_wino_tile_scheduler;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start_i;
  logic [ADDR_W-1:0] cfg_block_cnt_i;
  logic [ADDR_W-1:0] cfg_od_cnt_i;
  logic              cfg_size_type_i;
  logic              stall_i;
  logic              result_valid_i;
  logic              data_rd_en_o, wt_rd_en_o, pe_data_valid_o, pe_weight_valid_o;
  logic              pe_size_type_o, busy_o, done_o;
  logic [ADDR_W-1:0] data_rd_addr_o, wt_rd_addr_o, pe_data_addr_o, pe_weight_od_o, pe_block_cnt_o;

  wino_tile_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start_i           (start_i),
    .cfg_block_cnt_i   (cfg_block_cnt_i),
    .cfg_od_cnt_i      (cfg_od_cnt_i),
    .cfg_size_type_i   (cfg_size_type_i),
    .stall_i           (stall_i),
    .data_rd_en_o      (data_rd_en_o),
    .data_rd_addr_o    (data_rd_addr_o),
    .wt_rd_en_o        (wt_rd_en_o),
    .wt_rd_addr_o      (wt_rd_addr_o),
    .pe_data_valid_o   (pe_data_valid_o),
    .pe_data_addr_o    (pe_data_addr_o),
    .pe_size_type_o    (pe_size_type_o),
    .pe_block_cnt_o    (pe_block_cnt_o),
    .pe_weight_valid_o (pe_weight_valid_o),
    .pe_weight_od_o    (pe_weight_od_o),
    .result_valid_i    (result_valid_i),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: a pass is a queue of (blk, od) pairs in od-major order.
  int m_busy = 0, m_done = 0, m_total = 0, m_rcvd = 0, m_bc = 0, m_st = 0;
  int m_pe_v = 0, m_pe_blk = 0, m_pe_od = 0;
  int q_blk[$], q_od[$];
  int log_blk[$], log_od[$];
  int cyc = 0, m_start_cyc = 0, m_done_cyc = 0, n_done = 0, n_busy_cycles = 0;

  logic res_fast = 1'b1;
  logic res_spur = 1'b0;
  int   pending = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int exp_rd;
    cyc++;
    exp_rd = (m_busy != 0 && m_done == 0 && q_blk.size() > 0 && !stall_i) ? 1 : 0;
    chk("data_rd_en", int'(data_rd_en_o), exp_rd);
    chk("wt_rd_en", int'(wt_rd_en_o), exp_rd);
    if (exp_rd != 0) begin
      chk("data_rd_addr", int'(data_rd_addr_o), q_blk[0]);
      chk("wt_rd_addr", int'(wt_rd_addr_o), q_od[0]);
    end
    if (data_rd_en_o) begin
      log_blk.push_back(int'(data_rd_addr_o));
      log_od.push_back(int'(wt_rd_addr_o));
    end
    chk("pe_data_valid", int'(pe_data_valid_o), m_pe_v);
    chk("pe_weight_valid", int'(pe_weight_valid_o), m_pe_v);
    chk("pe_data_addr", int'(pe_data_addr_o), m_pe_blk);
    chk("pe_weight_od", int'(pe_weight_od_o), m_pe_od);
    chk("pe_block_cnt", int'(pe_block_cnt_o), m_bc);
    chk("pe_size_type", int'(pe_size_type_o), m_st);
    chk("busy", int'(busy_o), m_busy);
    chk("done", int'(done_o), m_done);
    if (done_o) begin
      n_done++;
      m_done_cyc = cyc;
    end
    if (busy_o) n_busy_cycles++;

    if (exp_rd != 0) begin
      m_pe_v = 1;
      m_pe_blk = q_blk.pop_front();
      m_pe_od = q_od.pop_front();
    end else begin
      m_pe_v = 0; m_pe_blk = 0; m_pe_od = 0;
    end
    if (reset) begin
      m_busy = 0; m_done = 0; m_total = 0; m_rcvd = 0; m_bc = 0; m_st = 0;
      m_pe_v = 0; m_pe_blk = 0; m_pe_od = 0;
      q_blk.delete(); q_od.delete();
    end else if (m_done != 0) begin
      m_busy = 0; m_done = 0;
    end else if (m_busy == 0) begin
      if (start_i) begin
        m_bc = int'(cfg_block_cnt_i);
        m_st = int'(cfg_size_type_i);
        m_total = int'(cfg_block_cnt_i) * int'(cfg_od_cnt_i);
        m_rcvd = 0;
        q_blk.delete(); q_od.delete();
        for (int o = 0; o < int'(cfg_od_cnt_i); o++)
          for (int b = 0; b < int'(cfg_block_cnt_i); b++) begin
            q_blk.push_back(b);
            q_od.push_back(o);
          end
        m_busy = 1;
        m_done = (m_total == 0) ? 1 : 0;
        m_start_cyc = cyc;
      end
    end else begin
      if (result_valid_i) m_rcvd++;
      if (q_blk.size() == 0 && m_rcvd == m_total) m_done = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Stand-in for the PE array: every PE valid later returns one result tile.
  initial begin
    result_valid_i = 1'b0;
    forever begin
      @(negedge clk);
      if (pe_data_valid_o) pending++;
      @(posedge clk);
      #1;
      if (res_spur) begin
        result_valid_i = ($urandom_range(1, 0) == 1);
      end else if (pending > 0 && (res_fast || $urandom_range(1, 0) == 1)) begin
        result_valid_i = 1'b1;
        pending--;
      end else begin
        result_valid_i = 1'b0;
      end
    end
  end

  task automatic run_pass(input int bc, input int od, input int st, input int stall_pct,
                          input int stall_lo, input int stall_hi, input int inject_at,
                          input int budget);
    int c;
    log_blk.delete(); log_od.delete();
    n_done = 0; n_busy_cycles = 0;
    cfg_block_cnt_i = ADDR_W'(bc);
    cfg_od_cnt_i    = ADDR_W'(od);
    cfg_size_type_i = st[0];
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    c = 0;
    while (n_done == 0 && c < budget) begin
      stall_i = (c >= stall_lo && c <= stall_hi) || (int'($urandom_range(99, 0)) < stall_pct);
      if (c == inject_at) begin
        start_i = 1'b1;
        cfg_block_cnt_i = ADDR_W'(bc + 4);
        cfg_od_cnt_i    = ADDR_W'(od + 3);
        cfg_size_type_i = ~st[0];
      end else begin
        start_i = 1'b0;
      end
      tick();
      c++;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    chk("pass_done_seen", n_done, 1);
    repeat (3) tick();
    chk("single_done", n_done, 1);
    chk("issue_count", log_blk.size(), bc * od);
  endtask

  task automatic chk_seq_3x2();
    int exp_b[6] = '{0, 1, 2, 0, 1, 2};
    int exp_o[6] = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      chk("seq_blk", (i < log_blk.size()) ? log_blk[i] : -1, exp_b[i]);
      chk("seq_od", (i < log_od.size()) ? log_od[i] : -1, exp_o[i]);
    end
  endtask

  initial begin
    int c;
    reset = 1'b1;
    start_i = 1'b0;
    stall_i = 1'b0;
    cfg_block_cnt_i = '0;
    cfg_od_cnt_i = '0;
    cfg_size_type_i = 1'b0;
    repeat (3) tick();
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_rd_en", int'(data_rd_en_o), 0);
    chk("reset_pe_block_cnt", int'(pe_block_cnt_o), 0);
    reset = 1'b0;
    tick();

    // Nominal 3x2 pass, fixed result return
    res_fast = 1'b1;
    run_pass(3, 2, 1, 0, -1, -1, -1, 100);
    chk_seq_3x2();
    chk("latency_3x2", m_done_cyc - m_start_cyc, 9);

    // Two stall cycles after the second issue
    run_pass(3, 2, 1, 0, 2, 3, -1, 100);
    chk_seq_3x2();
    chk("latency_stall", m_done_cyc - m_start_cyc, 11);

    // Zero block count
    run_pass(0, 5, 0, 0, -1, -1, -1, 50);
    chk("zero_busy_cycles", n_busy_cycles, 1);
    chk("zero_latency", m_done_cyc - m_start_cyc, 1);

    // Start while busy is ignored
    run_pass(3, 2, 1, 0, -1, -1, 2, 100);
    chk("held_block_cnt", int'(pe_block_cnt_o), 3);
    chk("held_size_type", int'(pe_size_type_o), 1);

    // Randomized passes with stall and slow result return
    res_fast = 1'b0;
    run_pass(1, 5, 0, 30, -1, -1, -1, 1000);
    for (int k = 0; k < 4; k++)
      run_pass(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)),
               int'($urandom_range(1, 0)), 30, -1, -1, -1, 1000);

    // Reset mid-pass, late results, then a fresh pass
    res_fast = 1'b1;
    log_blk.delete(); log_od.delete();
    cfg_block_cnt_i = 8'd4; cfg_od_cnt_i = 8'd4; cfg_size_type_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    c = 0;
    while (log_blk.size() < 4 && c < 50) begin tick(); c++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_busy", int'(busy_o), 0);
    chk("mid_reset_rd_en", int'(data_rd_en_o), 0);
    chk("mid_reset_pe_valid", int'(pe_data_valid_o), 0);
    chk("mid_reset_block_cnt", int'(pe_block_cnt_o), 0);
    chk("mid_reset_issues", log_blk.size(), 5);
    n_done = 0;
    res_spur = 1'b1;
    repeat (6) tick();
    res_spur = 1'b0;
    c = 0;
    while (pending > 0 && c < 50) begin tick(); c++; end
    repeat (2) tick();
    chk("mid_reset_no_done", n_done, 0);
    run_pass(4, 4, 1, 20, -1, -1, -1, 200);

    // Full-size pass
    run_pass(255, 255, 0, 0, -1, -1, -1, 66000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
